// File: rtl/uart_fifo_core_if.sv
// rtl/uart_fifo_core_if.sv - handshake bundle between the UART register wrapper and uart_fifo_core
interface uart_fifo_core_if #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
);
    localparam int TLW = $clog2(TX_DEPTH + 1);
    localparam int RLW = $clog2(RX_DEPTH + 1);

    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [TLW-1:0] tx_level;
    logic           tx_busy;
    logic [7:0]     rx_data;
    logic           rx_perr;
    logic           rx_ferr;
    logic           rx_valid;
    logic           rx_ready;
    logic [RLW-1:0] rx_level;
    logic           rx_overrun;
    logic           rx_overrun_clr;

    modport master (
        output tx_data, tx_valid, rx_ready, rx_overrun_clr,
        input  tx_ready, tx_level, tx_busy, rx_data, rx_perr, rx_ferr,
               rx_valid, rx_level, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, rx_overrun_clr,
        output tx_ready, tx_level, tx_busy, rx_data, rx_perr, rx_ferr,
               rx_valid, rx_level, rx_overrun
    );
endinterface

// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - full-duplex UART with TX/RX FIFOs and runtime frame format
module uart_fifo_core_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [W-1:0]                 wdata_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
    assign full_o  = (level_o == LW'(DEPTH));
    assign empty_o = (level_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level_o <= level_o + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end
endmodule

module uart_fifo_core #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int DIV_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_dbits_i,
    input  logic [1:0]       cfg_parity_i,
    input  logic             cfg_stop2_i,
    uart_fifo_core_if.slave  bus,
    input  logic             serial_rx_i,
    output logic             serial_tx_o
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DIV_W-1:0] div_eff;
    logic [7:0]       cfg_mask;
    logic             cfg_par_en;
    logic             cfg_odd;

    assign div_eff    = (cfg_div_i < DIV_W'(4)) ? DIV_W'(4) : cfg_div_i;
    assign cfg_mask   = 8'hFF >> (2'd3 - cfg_dbits_i);
    assign cfg_par_en = (cfg_parity_i == 2'b01) || (cfg_parity_i == 2'b10);
    assign cfg_odd    = (cfg_parity_i == 2'b10);

    // ---------------- TX ----------------
    logic [7:0]       tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_pop;
    logic             tx_line_d;
    state_t           tx_state;
    state_t           tx_state_nx;
    logic [DIV_W-1:0] tx_cnt;
    logic [DIV_W-1:0] tx_div;
    logic [2:0]       tx_idx;
    logic [1:0]       tx_dbits;
    logic [7:0]       tx_shift;
    logic             tx_par_en;
    logic             tx_par_bit;
    logic             tx_stop2;
    logic             tx_stop_idx;
    logic             tx_tick;
    logic             tx_stop_last;

    uart_fifo_core_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (bus.tx_valid),
        .wdata_i (bus.tx_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (bus.tx_level)
    );

    assign bus.tx_ready  = !tx_full;
    assign bus.tx_busy   = (tx_state != S_IDLE) || !tx_empty;
    assign tx_tick       = (tx_cnt == tx_div - DIV_W'(1));
    assign tx_stop_last  = (tx_stop_idx == tx_stop2);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) tx_state <= S_IDLE;
        else         tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            S_IDLE:   if (!tx_empty) tx_state_nx = S_START;
            S_START:  if (tx_tick) tx_state_nx = S_DATA;
            S_DATA:   if (tx_tick && tx_idx == {1'b1, tx_dbits})
                          tx_state_nx = tx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (tx_tick) tx_state_nx = S_STOP;
            S_STOP:   if (tx_tick && tx_stop_last)
                          tx_state_nx = tx_empty ? S_IDLE : S_START;
            default:  tx_state_nx = S_IDLE;
        endcase
    end

    // Popping in the last stop cycle chains the next frame with no idle gap.
    always_comb begin
        tx_pop    = !tx_empty && ((tx_state == S_IDLE) ||
                                  (tx_state == S_STOP && tx_tick && tx_stop_last));
        tx_line_d = 1'b1;
        case (tx_state)
            S_START:  tx_line_d = 1'b0;
            S_DATA:   tx_line_d = tx_shift[0];
            S_PARITY: tx_line_d = tx_par_bit;
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            serial_tx_o <= 1'b1;
            tx_cnt      <= '0;
            tx_div      <= DIV_W'(4);
            tx_idx      <= '0;
            tx_dbits    <= '0;
            tx_shift    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_stop_idx <= 1'b0;
        end else begin
            serial_tx_o <= tx_line_d;
            if (tx_pop) begin
                tx_cnt      <= '0;
                tx_div      <= div_eff;
                tx_idx      <= '0;
                tx_dbits    <= cfg_dbits_i;
                tx_shift    <= tx_head & cfg_mask;
                tx_par_en   <= cfg_par_en;
                tx_par_bit  <= (^(tx_head & cfg_mask)) ^ cfg_odd;
                tx_stop2    <= cfg_stop2_i;
                tx_stop_idx <= 1'b0;
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_idx   <= tx_idx + 3'd1;
                    end
                    if (tx_state == S_STOP) tx_stop_idx <= 1'b1;
                end else begin
                    tx_cnt <= tx_cnt + DIV_W'(1);
                end
            end
        end
    end

    // ---------------- RX ----------------
    logic [1:0]       rx_sync;
    logic             rx_s;
    logic             rx_prev;
    logic             rx_fall;
    state_t           rx_state;
    state_t           rx_state_nx;
    logic [DIV_W-1:0] rx_cnt;
    logic [DIV_W-1:0] rx_div;
    logic [2:0]       rx_idx;
    logic [1:0]       rx_dbits;
    logic [7:0]       rx_shift;
    logic             rx_xor;
    logic             rx_par_en;
    logic             rx_odd;
    logic             rx_perr;
    logic             rx_sample;
    logic             rx_push;
    logic             rx_full;
    logic             rx_empty;
    logic [9:0]       rx_wdata;
    logic [9:0]       rx_head;

    assign rx_s      = rx_sync[1];
    assign rx_fall   = rx_prev && !rx_s;
    assign rx_sample = (rx_state == S_START) ? (rx_cnt == (rx_div >> 1)) : (rx_cnt == rx_div);

    uart_fifo_core_fifo #(.DEPTH(RX_DEPTH), .W(10)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rx_push),
        .wdata_i (rx_wdata),
        .pop_i   (bus.rx_ready),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (bus.rx_level)
    );

    assign bus.rx_data  = rx_head[7:0];
    assign bus.rx_perr  = rx_head[8];
    assign bus.rx_ferr  = rx_head[9];
    assign bus.rx_valid = !rx_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rx_state <= S_IDLE;
        else         rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_state_nx = S_START;
            S_START:  if (rx_sample) rx_state_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (rx_sample && rx_idx == {1'b1, rx_dbits})
                          rx_state_nx = rx_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (rx_sample) rx_state_nx = S_STOP;
            S_STOP:   if (rx_sample) rx_state_nx = S_IDLE;
            default:  rx_state_nx = S_IDLE;
        endcase
    end

    // Data bits arrive at the top of rx_shift; realign to bit 0 for short frames.
    always_comb begin
        rx_push  = (rx_state == S_STOP) && rx_sample;
        rx_wdata = {!rx_s, rx_perr, rx_shift >> (2'd3 - rx_dbits)};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_sync        <= 2'b11;
            rx_prev        <= 1'b1;
            rx_cnt         <= '0;
            rx_div         <= DIV_W'(4);
            rx_idx         <= '0;
            rx_dbits       <= '0;
            rx_shift       <= '0;
            rx_xor         <= 1'b0;
            rx_par_en      <= 1'b0;
            rx_odd         <= 1'b0;
            rx_perr        <= 1'b0;
            bus.rx_overrun <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], serial_rx_i};
            rx_prev <= rx_s;
            if (rx_state == S_IDLE) begin
                if (rx_fall) begin
                    rx_cnt    <= DIV_W'(1);
                    rx_div    <= div_eff;
                    rx_idx    <= '0;
                    rx_dbits  <= cfg_dbits_i;
                    rx_shift  <= '0;
                    rx_xor    <= 1'b0;
                    rx_par_en <= cfg_par_en;
                    rx_odd    <= cfg_odd;
                    rx_perr   <= 1'b0;
                end
            end else if (rx_sample) begin
                rx_cnt <= DIV_W'(1);
                if (rx_state == S_DATA) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_xor   <= rx_xor ^ rx_s;
                    rx_idx   <= rx_idx + 3'd1;
                end
                if (rx_state == S_PARITY) rx_perr <= rx_s ^ rx_xor ^ rx_odd;
            end else begin
                rx_cnt <= rx_cnt + DIV_W'(1);
            end
            if (rx_push && rx_full)       bus.rx_overrun <= 1'b1;
            else if (bus.rx_overrun_clr)  bus.rx_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - self-checking bench for uart_fifo_core
module tb_uart_fifo_core;
    localparam int TXD = 8;
    localparam int RXD = 4;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] cfg_div;
    logic [1:0]    cfg_dbits;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          serial_rx;
    logic          serial_tx;
    logic          rx_drv;
    logic          loop_en;

    always #5 clk = ~clk;
    assign serial_rx = loop_en ? serial_tx : rx_drv;

    uart_fifo_core_if #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();

    uart_fifo_core #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .DIV_W(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_div_i    (cfg_div),
        .cfg_dbits_i  (cfg_dbits),
        .cfg_parity_i (cfg_parity),
        .cfg_stop2_i  (cfg_stop2),
        .bus          (bus.slave),
        .serial_rx_i  (serial_rx),
        .serial_tx_o  (serial_tx)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    bit   fq[$];
    int   eff, nb, falls, guard;
    logic [7:0] d, ed;
    bit   bp, bs, prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bit(s).
    task automatic append_frame(input logic [7:0] dd, input int nbits, input int par,
                                input int nstop, input bit bad_par, input bit bad_stop);
        bit p = 1'b0;
        fq.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            fq.push_back(dd[i]);
            p ^= dd[i];
        end
        if (par == 1) fq.push_back(p ^ bad_par);
        else if (par == 2) fq.push_back(!p ^ bad_par);
        fq.push_back(!bad_stop);
        if (nstop == 2) fq.push_back(1'b1);
    endtask

    task automatic push(input logic [7:0] dd);
        bus.tx_data  = dd;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
    endtask

    // Each expected bit must hold for exactly div cycles; checked at its first and last cycle.
    task automatic tx_watch(input int div);
        int  g = 0;
        logic f = 1'b1;
        @(negedge clk);
        while (serial_tx !== 1'b0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("tx_start_seen", 32'(serial_tx), 0);
        for (int i = 0; i < fq.size() * div; i++) begin
            if (i % div == 0) f = serial_tx;
            if (i % div == div - 1) chk("tx_bit", 32'({f, serial_tx}), 32'({fq[i/div], fq[i/div]}));
            if (i == div) chk("tx_busy_mid", 32'(bus.tx_busy), 1);
            @(negedge clk);
        end
        chk("tx_idle_after", 32'(serial_tx), 1);
        chk("tx_busy_after", 32'(bus.tx_busy), 0);
        fq.delete();
        @(posedge clk); #1;
    endtask

    task automatic rx_send(input int div);
        foreach (fq[k]) begin
            rx_drv = fq[k];
            repeat (div) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (2 * div + 4) @(posedge clk);
        #1;
        fq.delete();
    endtask

    task automatic rx_pop_chk(input logic [7:0] dd, input bit pe, input bit fe);
        chk("rx_valid", 32'(bus.rx_valid), 1);
        chk("rx_data", 32'(bus.rx_data), 32'(dd));
        chk("rx_perr", 32'(bus.rx_perr), 32'(pe));
        chk("rx_ferr", 32'(bus.rx_ferr), 32'(fe));
        bus.rx_ready = 1'b1;
        @(posedge clk); #1;
        bus.rx_ready = 1'b0;
    endtask

    task automatic set_cfg(input int div, input logic [1:0] db, input logic [1:0] pa, input logic s2);
        cfg_div = DW'(div); cfg_dbits = db; cfg_parity = pa; cfg_stop2 = s2;
    endtask

    initial begin
        set_cfg(16, 2'b11, 2'b00, 1'b0);
        rx_drv = 1'b1; loop_en = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0; bus.rx_overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial_tx", 32'(serial_tx), 1);
        chk("rst_tx_ready", 32'(bus.tx_ready), 1);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_tx_level", 32'(bus.tx_level), 0);
        chk("rst_rx_level", 32'(bus.rx_level), 0);
        chk("rst_overrun", 32'(bus.rx_overrun), 0);
        chk("rst_tx_busy", 32'(bus.tx_busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8N1 div 16, push 0xA5: pop at N+1, line low from N+2; cfg change mid-frame ignored
        push(8'hA5);
        chk("lat_level_n", 32'(bus.tx_level), 1);
        chk("lat_line_n", 32'(serial_tx), 1);
        @(posedge clk); #1;
        chk("lat_level_n1", 32'(bus.tx_level), 0);
        chk("lat_line_n1", 32'(serial_tx), 1);
        @(posedge clk); #1;
        chk("lat_line_n2", 32'(serial_tx), 0);
        set_cfg(5, 2'b00, 2'b01, 1'b1);
        append_frame(8'hA5, 8, 0, 1, 1'b0, 1'b0);
        tx_watch(16);

        // 7E2 loopback, two back-to-back frames
        set_cfg(16, 2'b10, 2'b01, 1'b1);
        loop_en = 1'b1;
        push(8'h3C);
        push(8'h41);
        append_frame(8'h3C, 7, 1, 2, 1'b0, 1'b0);
        append_frame(8'h41, 7, 1, 2, 1'b0, 1'b0);
        tx_watch(16);
        loop_en = 1'b0;
        chk("loop_rx_level", 32'(bus.rx_level), 2);
        rx_pop_chk(8'h3C, 1'b0, 1'b0);
        rx_pop_chk(8'h41, 1'b0, 1'b0);

        // 8O1 with wrong parity bit
        set_cfg(8, 2'b11, 2'b10, 1'b0);
        append_frame(8'h55, 8, 2, 1, 1'b1, 1'b0);
        rx_send(8);
        rx_pop_chk(8'h55, 1'b1, 1'b0);

        // 8N1 with bad stop bit
        set_cfg(8, 2'b11, 2'b00, 1'b0);
        append_frame(8'h81, 8, 0, 1, 1'b0, 1'b1);
        rx_send(8);
        rx_pop_chk(8'h81, 1'b0, 1'b1);

        // 3-cycle glitch is rejected, then a real frame is still received
        set_cfg(16, 2'b11, 2'b00, 1'b0);
        rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_rx_valid", 32'(bus.rx_valid), 0);
        chk("glitch_rx_level", 32'(bus.rx_level), 0);
        append_frame(8'h5A, 8, 0, 1, 1'b0, 1'b0);
        rx_send(16);
        rx_pop_chk(8'h5A, 1'b0, 1'b0);

        // Overrun: five frames into a 4-deep RX FIFO
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            append_frame(8'(i), 8, 0, 1, 1'b0, 1'b0);
            rx_send(4);
        end
        chk("ovr_level", 32'(bus.rx_level), 4);
        chk("ovr_flag", 32'(bus.rx_overrun), 1);
        for (int i = 1; i <= 4; i++) rx_pop_chk(8'(i), 1'b0, 1'b0);
        chk("ovr_level_empty", 32'(bus.rx_level), 0);
        chk("ovr_sticky", 32'(bus.rx_overrun), 1);
        bus.rx_overrun_clr = 1'b1;
        @(posedge clk); #1;
        bus.rx_overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(bus.rx_overrun), 0);

        // Random RX frames against the reference model (div<4 behaves as 4)
        for (int it = 0; it < 6; it++) begin
            set_cfg(int'($urandom_range(1, 10)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            eff = (cfg_div < 4) ? 4 : int'(cfg_div);
            d  = 8'($urandom);
            bp = 1'($urandom_range(0, 1));
            bs = ($urandom_range(0, 3) == 0);
            nb = 5 + int'(cfg_dbits);
            ed = '0;
            for (int i = 0; i < nb; i++) ed[i] = d[i];
            append_frame(d, nb, int'(cfg_parity), 1, bp, bs);
            rx_send(eff);
            chk("rx_rand_level", 32'(bus.rx_level), 1);
            rx_pop_chk(ed, (cfg_parity == 2'b01 || cfg_parity == 2'b10) && bp, bs);
        end

        // Random TX frames against the reference model
        for (int it = 0; it < 5; it++) begin
            set_cfg(int'($urandom_range(1, 10)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            eff = (cfg_div < 4) ? 4 : int'(cfg_div);
            d  = 8'($urandom);
            nb = 5 + int'(cfg_dbits);
            push(d);
            append_frame(d, nb, int'(cfg_parity), cfg_stop2 ? 2 : 1, 1'b0, 1'b0);
            tx_watch(eff);
        end

        // TX FIFO fill: 10 pushes, one in flight + 8 stored, the 10th dropped
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        bus.tx_data = 8'hFF; bus.tx_valid = 1'b1;
        falls = 0; prev = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (prev && !serial_tx) falls++;
            prev = serial_tx;
        end
        bus.tx_valid = 1'b0;
        chk("fill_level", 32'(bus.tx_level), 8);
        chk("fill_ready", 32'(bus.tx_ready), 0);
        guard = 0;
        while (bus.tx_busy && guard < 2000) begin
            @(negedge clk);
            if (prev && !serial_tx) falls++;
            prev = serial_tx;
            guard++;
        end
        chk("fill_drained", 32'(bus.tx_busy), 0);
        repeat (2) begin
            @(negedge clk);
            if (prev && !serial_tx) falls++;
            prev = serial_tx;
        end
        chk("fill_frames", 32'(falls), 9);
        @(posedge clk); #1;

        // Reset in the middle of a frame of zeros
        set_cfg(16, 2'b11, 2'b00, 1'b0);
        push(8'h00);
        push(8'h00);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_line_low", 32'(serial_tx), 0);
        chk("midrst_level_pre", 32'(bus.tx_level), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_line", 32'(serial_tx), 1);
        chk("midrst_tx_level", 32'(bus.tx_level), 0);
        chk("midrst_busy", 32'(bus.tx_busy), 0);
        chk("midrst_rx_level", 32'(bus.rx_level), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
